// File: rtl/bar_core.sv
// Streams the 6-byte banner "Bar X\n" (X = A..D) over a valid/ready byte
// interface on each accepted start, then pulses done and counts the message.
module bar_core #(
  parameter int         CNT_W        = 8,
  parameter logic [1:0] IDLE_VARIANT = 2'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       variant_sel,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] msg_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] idx;
  logic [1:0] variant_q;

  function automatic logic [7:0] msg_byte(input logic [2:0] i, input logic [1:0] v);
    logic [7:0] b;
    case (i)
      3'd0:    b = 8'h42;
      3'd1:    b = 8'h61;
      3'd2:    b = 8'h72;
      3'd3:    b = 8'h20;
      3'd4:    b = 8'h41 + {6'd0, v};
      default: b = 8'h0A;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= 3'd0;
      variant_q <= IDLE_VARIANT;
      msg_count <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_SEND;
            idx       <= 3'd0;
            variant_q <= variant_sel;
            out_data  <= msg_byte(3'd0, variant_sel);
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_SEND: begin
          // Everything holds while the sink stalls; advance only on a transfer.
          if (out_ready) begin
            if (idx == 3'd5) begin
              state     <= ST_DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= 8'h00;
              done      <= 1'b1;
              msg_count <= msg_count + CNT_W'(1);
            end else begin
              idx      <= idx + 3'd1;
              out_data <= msg_byte(idx + 3'd1, variant_q);
              out_last <= (idx == 3'd4);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bar_core.sv
// Randomised bench for bar_core: a message-level queue model predicts every
// cycle's outputs; a second instance with CNT_W=2 checks counter wrap.
module tb_bar_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] variant_sel = 2'd0;
  logic       out_ready = 1'b0;

  logic [7:0] out_data, out_data2;
  logic       out_valid, out_valid2, out_last, out_last2;
  logic       busy, busy2, done, done2;
  logic [7:0] msg_count;
  logic [1:0] msg_count2;

  bar_core #(.CNT_W(8), .IDLE_VARIANT(2'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .variant_sel(variant_sel),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .msg_count(msg_count)
  );

  bar_core #(.CNT_W(2), .IDLE_VARIANT(2'd0)) dut2 (
    .clk(clk), .rst(rst), .start(start), .variant_sel(variant_sel),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_last(out_last2), .busy(busy2), .done(done2), .msg_count(msg_count2)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: bytes still owed for the current message, a pending done cycle,
  // and the total number of completed messages since reset.
  logic [7:0] exp_q[$];
  bit         m_done = 1'b0;
  int         m_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    bit v;
    v = (exp_q.size() > 0);
    chk("out_valid", {31'd0, out_valid}, {31'd0, v});
    chk("busy", {31'd0, busy}, {31'd0, (v || m_done)});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("msg_count", {24'd0, msg_count}, m_cnt % 256);
    chk("msg_count_w2", {30'd0, msg_count2}, m_cnt % 4);
    if (v) begin
      chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0]});
      chk("out_last", {31'd0, out_last}, {31'd0, (exp_q.size() == 1)});
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_last", {31'd0, out_last}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_data", {24'd0, out_data}, 0);
    chk("rst_count", {24'd0, msg_count}, 0);
    chk("rst_count_w2", {30'd0, msg_count2}, 0);
  endtask

  task automatic queue_message(input logic [1:0] v);
    string m;
    m = "Bar X\n";
    m.putc(4, 8'h41 + {6'd0, v});
    for (int i = 0; i < m.len(); i++) exp_q.push_back(m.getc(i));
  endtask

  // Called at a negedge: drive inputs, advance the model over the next
  // rising edge, then compare at the following negedge.
  task automatic step(input logic s, input logic [1:0] v, input logic r);
    start = s;
    variant_sel = v;
    out_ready = r;
    if (exp_q.size() == 0 && !m_done) begin
      if (s) queue_message(v);
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (r) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) begin
        m_done = 1'b1;
        m_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_reset_vals();
    exp_q.delete();
    m_done = 1'b0;
    m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();
    @(negedge clk);
    check_all();

    // Plain message, variant A, sink always ready.
    step(1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 2'd0, 1'b1);

    // Variant D latched; variant_sel moves to B mid-message.
    step(1'b1, 2'd3, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 2'd1, 1'b1);

    // Backpressure pattern 1,0,0,1,...
    step(1'b1, 2'd2, 1'b0);
    for (int i = 0; i < 24; i++) step(1'b0, 2'd2, (i % 3) != 1 && (i % 3) != 2);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b1);

    // Start held every cycle: starts while busy must be dropped.
    for (int i = 0; i < 40; i++) step(1'b1, 2'(i), 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 1'b1);

    // Reset after the 3rd byte transfers, then a full message again.
    step(1'b1, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd1, 1'b1);
    #2;
    do_reset();
    @(negedge clk);
    check_all();
    step(1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 2'd0, 1'b1);

    // Five back-to-back messages to exercise the narrow counter wrap.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 2'(k), 1'b1);
      for (int i = 0; i < 7; i++) step(1'b0, 2'd0, 1'b1);
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step(($urandom % 4) == 0, 2'($urandom), ($urandom % 3) != 0);
    for (int i = 0; i < 40; i++) step(1'b0, 2'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bar_core.md
Name: bar_core

Overview:
- Small banner/message streaming engine, the companion block to the `foo` banner module at testbench top level.
- On a start pulse it emits the 6-byte ASCII message "Bar X\n" over a valid/ready byte stream, where X is a variant letter A–D.
- It counts completed messages and signals completion, so top-level benches can synchronise end-of-test on it.

Parameters:
- CNT_W, 8: width of the completed-message counter.
- IDLE_VARIANT, 2'd0: value `variant_q` takes on reset (0=A).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one message; sampled only in IDLE.
- variant_sel  input  2  letter select: 0=A, 1=B, 2=C, 3=D; latched with start.
- out_data  output  8  current ASCII byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  sink accepts byte when high with out_valid.
- out_last  output  1  high with the final byte ('\n').
- busy  output  1  high whenever not IDLE.
- done  output  1  one-cycle pulse after the last byte transfers.
- msg_count  output  CNT_W  number of completed messages, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, idx=0, variant_q=IDLE_VARIANT, msg_count=0.
- Reset values of the remaining outputs: out_valid=0, out_last=0, done=0, busy=0, out_data=8'h00.
- Message bytes, by idx:
  - 0: 'B' (0x42)
  - 1: 'a' (0x61)
  - 2: 'r' (0x72)
  - 3: ' ' (0x20)
  - 4: 0x41+variant_q ('A'..'D')
  - 5: '\n' (0x0A)
- States: IDLE, SEND, DONE.
- IDLE:
  - start=1 at edge N: latch variant_sel, idx=0, go to SEND.
  - out_valid=1 with 'B' from cycle N+1; busy=1 from N+1.
- SEND:
  - out_valid=1 and out_data=byte[idx], all registered.
  - Transfer occurs on an edge where out_valid&&out_ready.
  - After a transfer with idx<5: idx++.
  - After a transfer with idx==5: go to DONE, out_valid=0.
  - out_last=1 exactly while idx==5 and out_valid=1.
- Backpressure: while out_valid&&!out_ready, out_data, out_last and idx hold stable. There are no bubbles between bytes when out_ready stays high.
- DONE:
  - Lasts one cycle: done=1, busy=1, out_valid=0.
  - msg_count increments on the edge entering DONE (visible during DONE).
  - Next state is IDLE.
- Latency with out_ready tied high: start at N gives bytes on N+1..N+6, done at N+7, IDLE (busy=0) at N+8. Earliest next accepted start is at N+8.
- start while busy: ignored, not queued. variant_sel changes while busy have no effect.
- msg_count at 2^CNT_W−1 wraps to 0 on the next completion.
- Reset mid-message:
  - Output goes immediately to reset values; no done pulse and no count increment.
  - The partial message is abandoned and the next start sends a full message from 'B'.
- out_ready is ignored when out_valid=0.
- Simultaneous start and DONE state: start is ignored (not IDLE).
- No combinational path from inputs to any output.

Test Plan:
- Reset, then start=1 with variant_sel=0 and out_ready=1 -> bytes 42,61,72,20,41,0A on consecutive cycles; out_last only on 0A; done pulse one cycle later; msg_count=1.
- variant_sel=3 with start, then change variant_sel to 1 mid-message -> byte 4 is 0x44 ('D').
- out_ready toggled 1,0,0,1,... -> each byte held stable while stalled; byte order unchanged; exactly 6 transfers; done only after the '\n' transfer.
- start pulsed every cycle -> one message per 8 cycles; starts during busy are dropped; msg_count increments once per message.
- rst asserted after the 3rd byte -> outputs go to 0 asynchronously with no done pulse and msg_count=0; a new start yields a full "Bar A\n".
- CNT_W=2, run 5 messages -> msg_count sequence 1,2,3,0,1.
